gp_fifo_param: RTL and testbench

Parametrised synchronous FIFO for the NoC router read/write buffers. It generalises the fixed 32x64 buffer in four ways: configurable width and depth, a full occupancy count (0..DEPTH inclusive), programmable almost-full/almost-empty thresholds, and simultaneous read+write while full. It also adds a flush input, sticky overflow/underflow flags and a peak-occupancy watermark. Everything runs in a single clock domain; router input ports and NI buffers instantiate it directly.

---
 rtl/gp_fifo_param_if.sv | 23 ++
 rtl/gp_fifo_param.sv | 84 ++++++++
 tb/tb_gp_fifo_param.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/gp_fifo_param_if.sv
// Handshake and data bundle between a FIFO user (master) and gp_fifo_param (slave).
interface gp_fifo_param_if #(
  parameter int DATA_W = 64
);
  logic              write_en;
  logic              read_en;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;

  modport master (
    output write_en, read_en, data_in,
    input  data_out, full, empty, almost_full, almost_empty
  );

  modport slave (
    input  write_en, read_en, data_in,
    output data_out, full, empty, almost_full, almost_empty
  );
endinterface

// File: rtl/gp_fifo_param.sv
// Parametrised show-ahead synchronous FIFO with occupancy, thresholds, flush,
// sticky overflow/underflow flags and a peak-occupancy watermark.
module gp_fifo_param #(
  parameter int DATA_W     = 64,
  parameter int DEPTH_LOG2 = 5,
  parameter int AFULL_TH   = (1 << DEPTH_LOG2) - 4,
  parameter int AEMPTY_TH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  clear_err,
  gp_fifo_param_if.slave        bus,
  output logic [DEPTH_LOG2:0]   ocup,
  output logic [DEPTH_LOG2:0]   peak_ocup,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [PW-1:0] DEPTH_V  = PW'(DEPTH);
  localparam logic [PW-1:0] AFULL_V  = PW'(AFULL_TH);
  localparam logic [PW-1:0] AEMPTY_V = PW'(AEMPTY_TH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr_next;
  logic [PW-1:0]     rd_ptr_next;
  logic [PW-1:0]     ocup_next;
  logic              wr_ok;
  logic              rd_ok;
  logic              ovf_evt;
  logic              udf_evt;

  assign ocup             = wr_ptr - rd_ptr;
  assign bus.full         = (ocup == DEPTH_V);
  assign bus.empty        = (ocup == '0);
  assign bus.almost_full  = (ocup >= AFULL_V);
  assign bus.almost_empty = (ocup <= AEMPTY_V);
  assign bus.data_out     = bus.empty ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];

  // A write on full only goes through when a read frees the head slot.
  assign rd_ok = bus.read_en && !bus.empty && !flush;
  assign wr_ok = bus.write_en && (!bus.full || rd_ok) && !flush;

  assign ovf_evt = !flush && bus.write_en && !wr_ok;
  assign udf_evt = !flush && bus.read_en && bus.empty;

  assign wr_ptr_next = flush ? '0 : wr_ptr + PW'(wr_ok);
  assign rd_ptr_next = flush ? '0 : rd_ptr + PW'(rd_ok);
  assign ocup_next   = wr_ptr_next - rd_ptr_next;

  always_ff @(posedge clk) begin
    if (reset && wr_ok) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= bus.data_in;
    end
  end

  // A rejection in the same cycle as clear_err leaves its flag set.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      peak_ocup <= '0;
    end else begin
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
      if (clear_err) begin
        overflow  <= ovf_evt;
        underflow <= udf_evt;
        peak_ocup <= ocup_next;
      end else begin
        if (ovf_evt) overflow <= 1'b1;
        if (udf_evt) underflow <= 1'b1;
        if (ocup_next > peak_ocup) peak_ocup <= ocup_next;
      end
    end
  end

endmodule

// File: tb/tb_gp_fifo_param.sv
// Directed bench for gp_fifo_param: a vector table for basic behaviour plus
// hand-written sequences for fill/overflow, full-rate wrap, flush and reset.
module tb_gp_fifo_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       flush = 1'b0;
  logic       clear_err = 1'b0;
  logic [5:0] ocup;
  logic [5:0] peak_ocup;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int failures = 0;

  gp_fifo_param_if #(.DATA_W(64)) bus ();

  gp_fifo_param #(
    .DATA_W(64), .DEPTH_LOG2(5), .AFULL_TH(28), .AEMPTY_TH(2)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .clear_err(clear_err),
    .bus(bus), .ocup(ocup), .peak_ocup(peak_ocup),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        we;
    logic        re;
    logic        fl;
    logic        ce;
    logic [63:0] d;
    logic [5:0]  e_ocup;
    logic [5:0]  e_peak;
    logic        e_full;
    logic        e_empty;
    logic        e_af;
    logic        e_ae;
    logic        e_ov;
    logic        e_uf;
    logic [63:0] e_dout;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic rst, input logic we, input logic re,
                     input logic fl, input logic ce, input logic [63:0] d);
    @(negedge clk);
    reset = rst;
    bus.write_en = we;
    bus.read_en = re;
    flush = fl;
    clear_err = ce;
    bus.data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
  endtask

  task automatic idle_inputs();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
  endtask

  vec_t vecs[14];

  initial begin
    bus.write_en = 1'b0;
    bus.read_en = 1'b0;
    bus.data_in = 64'h0;

    //           rst   we    re    fl    ce    d        ocup   peak   full  empty af    ae    ov    uf    dout
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,  6'd0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,  6'd0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h11, 6'd1, 6'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h11};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h22, 6'd2, 6'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h11};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h33, 6'd3, 6'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h11};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'h44, 6'd3, 6'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h22};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0,  6'd2, 6'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h33};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0,  6'd1, 6'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h44};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0,  6'd0, 6'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0,  6'd0, 6'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0,  6'd0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0,  6'd0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'h55, 6'd1, 6'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h55};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'h66, 6'd0, 6'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0};

    for (int i = 0; i < 14; i++) begin
      cyc(vecs[i].rst, vecs[i].we, vecs[i].re, vecs[i].fl, vecs[i].ce, vecs[i].d);
      chk($sformatf("v%0d.ocup", i),  64'(ocup),           64'(vecs[i].e_ocup));
      chk($sformatf("v%0d.peak", i),  64'(peak_ocup),      64'(vecs[i].e_peak));
      chk($sformatf("v%0d.full", i),  64'(bus.full),       64'(vecs[i].e_full));
      chk($sformatf("v%0d.empty", i), 64'(bus.empty),      64'(vecs[i].e_empty));
      chk($sformatf("v%0d.afull", i), 64'(bus.almost_full),  64'(vecs[i].e_af));
      chk($sformatf("v%0d.aempty", i), 64'(bus.almost_empty), 64'(vecs[i].e_ae));
      chk($sformatf("v%0d.ovf", i),   64'(overflow),       64'(vecs[i].e_ov));
      chk($sformatf("v%0d.udf", i),   64'(underflow),      64'(vecs[i].e_uf));
      chk($sformatf("v%0d.dout", i),  bus.data_out,        vecs[i].e_dout);
    end

    // Fill to full, reject a 33rd write, drain in order.
    do_reset();
    for (int i = 1; i <= 32; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'(i));
      chk($sformatf("fill.ocup%0d", i), 64'(ocup), 64'(i));
      chk($sformatf("fill.afull%0d", i), 64'(bus.almost_full), (i >= 28) ? 64'd1 : 64'd0);
    end
    chk("fill.full", 64'(bus.full), 64'd1);
    chk("fill.ovf_before", 64'(overflow), 64'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'hDEAD);
    chk("ovf.flag", 64'(overflow), 64'd1);
    chk("ovf.ocup", 64'(ocup), 64'd32);
    chk("ovf.full", 64'(bus.full), 64'd1);
    chk("ovf.peak", 64'(peak_ocup), 64'd32);
    for (int i = 1; i <= 32; i++) begin
      chk($sformatf("drain.dout%0d", i), bus.data_out, 64'(i));
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
    end
    chk("drain.empty", 64'(bus.empty), 64'd1);
    chk("drain.dout_empty", bus.data_out, 64'h0);
    chk("drain.udf", 64'(underflow), 64'd0);

    // Full-rate read+write while full, across pointer wrap.
    do_reset();
    for (int i = 1; i <= 32; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'(i));
    for (int k = 0; k < 40; k++) begin
      chk($sformatf("rw.dout%0d", k), bus.data_out, 64'(k + 1));
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'(33 + k));
      chk($sformatf("rw.ocup%0d", k), 64'(ocup), 64'd32);
    end
    chk("rw.ovf", 64'(overflow), 64'd0);
    for (int k = 41; k <= 72; k++) begin
      chk($sformatf("rw.tail%0d", k), bus.data_out, 64'(k));
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
    end
    chk("rw.empty", 64'(bus.empty), 64'd1);

    // Read+write together on empty: read rejected, write lands.
    do_reset();
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'hA5);
    chk("rwe.udf", 64'(underflow), 64'd1);
    chk("rwe.ocup", 64'(ocup), 64'd1);
    chk("rwe.dout", bus.data_out, 64'hA5);
    chk("rwe.ovf", 64'(overflow), 64'd0);

    // Flush with a concurrent write, then clear the watermark.
    do_reset();
    for (int i = 1; i <= 10; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'(i + 100));
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'hBEEF);
    chk("flush.ocup", 64'(ocup), 64'd0);
    chk("flush.empty", 64'(bus.empty), 64'd1);
    chk("flush.ovf", 64'(overflow), 64'd0);
    chk("flush.peak", 64'(peak_ocup), 64'd10);
    chk("flush.dout", bus.data_out, 64'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0);
    chk("clr.peak", 64'(peak_ocup), 64'd0);
    idle_inputs();
    chk("clr.idle_ocup", 64'(ocup), 64'd0);

    // Mid-operation reset with write_en high.
    do_reset();
    for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'(i + 200));
    chk("pre_rst.ocup", 64'(ocup), 64'd5);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h99);
    chk("rst.ocup", 64'(ocup), 64'd0);
    chk("rst.peak", 64'(peak_ocup), 64'd0);
    chk("rst.dout", bus.data_out, 64'h0);
    chk("rst.empty", 64'(bus.empty), 64'd1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h77);
    chk("post_rst.ocup", 64'(ocup), 64'd1);
    chk("post_rst.dout", bus.data_out, 64'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
